// File: rtl/expipe_pkg.sv
// Execution-pipeline shared types: ROB/CDB widths and the CDB broadcast word.
package expipe_pkg;

    localparam int XLEN           = 32;
    localparam int ROB_IDX_LEN    = 4;
    localparam int ROB_EXCEPT_LEN = 4;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0]    rob_idx;
        logic [XLEN-1:0]           res_value;
        logic                      except_raised;
        logic [ROB_EXCEPT_LEN-1:0] except_code;
    } cdb_data_t;

    function automatic cdb_data_t cdb_pack(
        input logic [ROB_IDX_LEN-1:0]    idx,
        input logic [XLEN-1:0]           value,
        input logic                      except_raised,
        input logic [ROB_EXCEPT_LEN-1:0] except_code
    );
        cdb_data_t w;
        w.rob_idx       = idx;
        w.res_value     = value;
        w.except_raised = except_raised;
        w.except_code   = except_code;
        return w;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Priority encoder: index of the lowest set request bit, lane 0 highest.
module prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    // Scan downward so the lowest requesting lane is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lanes at or above ptr_i win first, otherwise wrap to lane 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  mask;
    logic [N-1:0]  masked_req;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] u_idx;
    logic          m_valid;
    logic          u_valid;

    // Keep only lanes at or above the pointer for the first-choice search.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr_i));
        end
        masked_req = req_i & mask;
    end

    prio_enc #(.N(N)) u_masked (
        .req_i   (masked_req),
        .idx_o   (m_idx),
        .valid_o (m_valid)
    );

    prio_enc #(.N(N)) u_unmasked (
        .req_i   (req_i),
        .idx_o   (u_idx),
        .valid_o (u_valid)
    );

    // Prefer the masked winner; the unmasked one covers the wrap-around case.
    always_comb begin
        gnt_idx_o = m_valid ? m_idx : u_idx;
        valid_o   = u_valid;
        gnt_o     = '0;
        if (u_valid) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one reservation-station result per cycle,
// registers it in a single-entry output register and broadcasts it to the ROB.
module cdb_arbiter
    import expipe_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  flush_i,
    input  logic [N_REQ-1:0]                      rs_valid_i,
    output logic [N_REQ-1:0]                      rs_ready_o,
    input  logic [N_REQ-1:0][ROB_IDX_LEN-1:0]     rs_idx_i,
    input  logic [N_REQ-1:0][XLEN-1:0]            rs_data_i,
    input  logic [N_REQ-1:0]                      rs_except_raised_i,
    input  logic [N_REQ-1:0][ROB_EXCEPT_LEN-1:0]  rs_except_i,
    input  logic                                  rob_ready_i,
    output logic                                  cdb_valid_o,
    output logic [ROB_IDX_LEN-1:0]                cdb_idx_o,
    output logic [XLEN-1:0]                       cdb_data_o,
    output logic                                  cdb_except_raised_o,
    output logic [ROB_EXCEPT_LEN-1:0]             cdb_except_o
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    arb_ptr;
    logic [IW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             arb_valid;
    logic             slot_free;
    logic             grant_en;
    logic             cdb_valid_q;
    cdb_data_t        cdb_q;
    cdb_data_t        cdb_d;

    // Fixed-priority mode simply pins the search start at lane 0.
    assign arb_ptr = RR_EN ? rr_ptr : '0;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i     (rs_valid_i),
        .ptr_i     (arb_ptr),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .valid_o   (arb_valid)
    );

    // Grant only when the output register will be free at the next edge and no flush is pending.
    always_comb begin
        slot_free  = !cdb_valid_q || rob_ready_i;
        grant_en   = slot_free && !flush_i && arb_valid;
        rs_ready_o = grant_en ? gnt : '0;
        cdb_d      = cdb_pack(rs_idx_i[gnt_idx], rs_data_i[gnt_idx],
                              rs_except_raised_i[gnt_idx], rs_except_i[gnt_idx]);
    end

    // Output register and round-robin pointer; flush drops the pending word but keeps the pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
            rr_ptr      <= '0;
        end else if (flush_i) begin
            cdb_valid_q <= 1'b0;
        end else if (grant_en) begin
            cdb_valid_q <= 1'b1;
            cdb_q       <= cdb_d;
            rr_ptr      <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end else if (rob_ready_i) begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign cdb_valid_o         = cdb_valid_q;
    assign cdb_idx_o           = cdb_q.rob_idx;
    assign cdb_data_o          = cdb_q.res_value;
    assign cdb_except_raised_o = cdb_q.except_raised;
    assign cdb_except_o        = cdb_q.except_code;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared against a modular-arithmetic reference model.
module tb_cdb_arbiter;
    import expipe_pkg::*;

    localparam int N  = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                                 flush;
    logic [N-1:0]                         rs_valid;
    logic [N-1:0]                         rs_ready;
    logic [N-1:0][ROB_IDX_LEN-1:0]        rs_idx;
    logic [N-1:0][XLEN-1:0]               rs_data;
    logic [N-1:0]                         rs_er;
    logic [N-1:0][ROB_EXCEPT_LEN-1:0]     rs_ec;
    logic                                 rob_ready;
    logic                                 cdb_valid;
    logic [ROB_IDX_LEN-1:0]               cdb_idx;
    logic [XLEN-1:0]                      cdb_data;
    logic                                 cdb_er;
    logic [ROB_EXCEPT_LEN-1:0]            cdb_ec;

    logic [N3-1:0]                        rs_valid3;
    logic [N3-1:0]                        rs_ready3;
    logic [N3-1:0][ROB_IDX_LEN-1:0]       rs_idx3;
    logic [N3-1:0][XLEN-1:0]              rs_data3;
    logic [N3-1:0]                        rs_er3;
    logic [N3-1:0][ROB_EXCEPT_LEN-1:0]    rs_ec3;
    logic                                 cdb_valid3;
    logic [ROB_IDX_LEN-1:0]               cdb_idx3;
    logic [XLEN-1:0]                      cdb_data3;
    logic                                 cdb_er3;
    logic [ROB_EXCEPT_LEN-1:0]            cdb_ec3;

    cdb_arbiter #(.N_REQ(N), .RR_EN(1'b1)) u_dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .flush_i             (flush),
        .rs_valid_i          (rs_valid),
        .rs_ready_o          (rs_ready),
        .rs_idx_i            (rs_idx),
        .rs_data_i           (rs_data),
        .rs_except_raised_i  (rs_er),
        .rs_except_i         (rs_ec),
        .rob_ready_i         (rob_ready),
        .cdb_valid_o         (cdb_valid),
        .cdb_idx_o           (cdb_idx),
        .cdb_data_o          (cdb_data),
        .cdb_except_raised_o (cdb_er),
        .cdb_except_o        (cdb_ec)
    );

    cdb_arbiter #(.N_REQ(N3), .RR_EN(1'b1)) u_dut3 (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .flush_i             (1'b0),
        .rs_valid_i          (rs_valid3),
        .rs_ready_o          (rs_ready3),
        .rs_idx_i            (rs_idx3),
        .rs_data_i           (rs_data3),
        .rs_except_raised_i  (rs_er3),
        .rs_except_i         (rs_ec3),
        .rob_ready_i         (1'b1),
        .cdb_valid_o         (cdb_valid3),
        .cdb_idx_o           (cdb_idx3),
        .cdb_data_o          (cdb_data3),
        .cdb_except_raised_o (cdb_er3),
        .cdb_except_o        (cdb_ec3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int                         ptr;
    bit                         m_valid;
    logic [ROB_IDX_LEN-1:0]     m_idx;
    logic [XLEN-1:0]            m_data;
    logic                       m_er;
    logic [ROB_EXCEPT_LEN-1:0]  m_ec;
    int                         last_grant;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_rs(input int k, input logic [ROB_IDX_LEN-1:0] idx, input logic [XLEN-1:0] data,
                          input logic er, input logic [ROB_EXCEPT_LEN-1:0] ec);
        rs_idx[k]  = idx;
        rs_data[k] = data;
        rs_er[k]   = er;
        rs_ec[k]   = ec;
    endtask

    task automatic rand_fields();
        for (int k = 0; k < N; k++) begin
            set_rs(k, ROB_IDX_LEN'($urandom), $urandom, 1'($urandom), ROB_EXCEPT_LEN'($urandom));
        end
    endtask

    task automatic model_clear();
        ptr     = 0;
        m_valid = 0;
        m_idx   = '0;
        m_data  = '0;
        m_er    = 1'b0;
        m_ec    = '0;
    endtask

    // One cycle: called at a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        int g;
        int k;
        logic [N-1:0] exp_rdy;
        #1;
        g = -1;
        if ((!m_valid || rob_ready) && !flush) begin
            for (int off = N - 1; off >= 0; off--) begin
                k = (ptr + off) % N;
                if (rs_valid[k]) g = k;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("rs_ready", rs_ready, exp_rdy);
        chk("cdb_valid", cdb_valid, m_valid);
        chk("cdb_idx", cdb_idx, m_idx);
        chk("cdb_data", cdb_data, m_data);
        chk("cdb_er", cdb_er, m_er);
        chk("cdb_ec", cdb_ec, m_ec);
        last_grant = g;
        @(posedge clk);
        if (flush) begin
            m_valid = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_idx   = rs_idx[g];
            m_data  = rs_data[g];
            m_er    = rs_er[g];
            m_ec    = rs_ec[g];
            ptr     = (g + 1) % N;
        end else if (rob_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flush    = 1'b0;
        rs_valid = '0;
        rob_ready = 1'b1;
        #1;
        chk("rst_valid", cdb_valid, 0);
        chk("rst_ready", rs_ready, 0);
        chk("rst_idx", cdb_idx, 0);
        chk("rst_data", cdb_data, 0);
        chk("rst_er", cdb_er, 0);
        chk("rst_ec", cdb_ec, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        flush     = 1'b0;
        rs_valid  = '0;
        rob_ready = 1'b1;
        rs_idx    = '0;
        rs_data   = '0;
        rs_er     = '0;
        rs_ec     = '0;
        rs_valid3 = '0;
        rs_idx3   = '0;
        rs_data3  = '0;
        rs_er3    = '0;
        rs_ec3    = '0;
        do_reset();

        // single request, one-cycle latency, pointer moves past the winner
        rs_valid = 4'b0100;
        set_rs(2, 4'd5, 32'hAB, 1'b0, 4'd0);
        step();
        chk("t1_grant", last_grant, 2);
        rs_valid = '0;
        #1;
        chk("t1_cdb_valid", cdb_valid, 1);
        chk("t1_cdb_idx", cdb_idx, 5);
        chk("t1_cdb_data", cdb_data, 32'hAB);
        step();
        rs_valid = 4'b1111;
        step();
        chk("t1_ptr3", last_grant, 3);

        // all requesting: strict rotation, no bubbles
        do_reset();
        rs_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            step();
            chk("t2_order", last_grant, i % N);
            chk("t2_cdb_valid", cdb_valid, 1);
        end

        // ROB backpressure holds the word, then RS0 wins without a bubble
        rob_ready = 1'b0;
        rs_valid  = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            step();
            chk("t3_stall", last_grant, -1);
        end
        rob_ready = 1'b1;
        step();
        chk("t3_grant0", last_grant, 0);
        chk("t3_no_bubble", cdb_valid, 1);

        // flush drops the pending word and keeps the pointer
        rs_valid = 4'b1000;
        flush    = 1'b1;
        step();
        chk("t4_flush_grant", last_grant, -1);
        flush    = 1'b0;
        rs_valid = '0;
        chk("t4_dropped", cdb_valid, 0);
        rs_valid = 4'b1111;
        step();
        chk("t4_ptr_kept", last_grant, 1);

        // pointer wrap
        rs_valid = 4'b0100;
        step();
        rs_valid = 4'b0001;
        step();
        chk("t5_wrap_grant", last_grant, 0);
        rs_valid = 4'b1111;
        step();
        chk("t5_ptr1", last_grant, 1);

        // three-lane instance: pointer 2 wraps to 0
        rs_valid  = '0;
        rs_valid3 = 3'b100;
        #1;
        chk("n3_grant2", rs_ready3, 3'b100);
        step();
        rs_valid3 = 3'b111;
        #1;
        chk("n3_wrap0", rs_ready3, 3'b001);
        step();
        rs_valid3 = '0;

        // exception passthrough, then async reset mid-hold
        rs_valid = 4'b0010;
        set_rs(1, 4'd7, $urandom, 1'b1, 4'd3);
        step();
        rs_valid  = '0;
        rob_ready = 1'b0;
        #1;
        chk("t6_er", cdb_er, 1);
        chk("t6_ec", cdb_ec, 3);
        chk("t6_idx", cdb_idx, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", cdb_valid, 0);
        chk("t6_rst_data", cdb_data, 0);
        model_clear();
        @(negedge clk);
        rst_n     = 1'b1;
        rob_ready = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rs_valid  = N'($urandom);
            rob_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rand_fields();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
